// File: rtl/pipe_collision_check_pkg.sv
// Shared constants and types for the bird/pipe collision checker.
// The screen and scope constants match the ones the pipe X-coordinate store uses,
// so both blocks agree on where a pipe is in or out of scope.
package pipe_collision_check_pkg;

   // Screen geometry
   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;
   localparam int SCOPE_X  = 230;  // pipe store drops a pipe from scope at this X

   // Bird box defaults
   localparam int BIRD_X_L_DEF   = 200;
   localparam int BIRD_X_R_DEF   = SCOPE_X - 1;          // 229
   localparam int BIRD_H_DEF     = 20;
   localparam int FLOOR_Y_DEF    = SCREEN_H - BIRD_H_DEF; // 460
   localparam int CEIL_Y_DEF     = 0;
   localparam int HIT_FRAMES_DEF = 2;

   // One-hot FSM encoding
   typedef enum logic [3:0] {
      S_IDLE  = 4'b0001,
      S_ARMED = 4'b0010,
      S_EVAL  = 4'b0100,
      S_HIT   = 4'b1000
   } coll_state_e;

   // Stage-1 capture of the per-frame geometry
   typedef struct packed {
      logic [9:0] x_l;
      logic [9:0] x_r;
      logic [9:0] gap_top;
      logic [9:0] gap_bot;
      logic [9:0] bird_y;
   } coll_cap_t;

endpackage

// File: rtl/pipe_collision_check_if.sv
// Handshake/data bundle between the game (master) and the collision checker (slave).
//   Frame_Tick, Q_Count, Ack               : control from the game
//   X_Edge_OO_L/R, Gap_Top/Bot, Bird_Y     : geometry of the in-scope pipe and bird
//   Stop, Hit_Pipe, Hit_Floor, Q_*         : status back to the game
interface pipe_collision_check_if;
   logic       Frame_Tick;
   logic       Q_Count;
   logic       Ack;
   logic [9:0] X_Edge_OO_L;
   logic [9:0] X_Edge_OO_R;
   logic [9:0] Gap_Top;
   logic [9:0] Gap_Bot;
   logic [9:0] Bird_Y;
   logic       Stop;
   logic       Hit_Pipe;
   logic       Hit_Floor;
   logic       Q_Idle;
   logic       Q_Armed;
   logic       Q_Eval;
   logic       Q_Hit;

   modport master (
      output Frame_Tick, Q_Count, Ack, X_Edge_OO_L, X_Edge_OO_R, Gap_Top, Gap_Bot, Bird_Y,
      input  Stop, Hit_Pipe, Hit_Floor, Q_Idle, Q_Armed, Q_Eval, Q_Hit
   );

   modport slave (
      input  Frame_Tick, Q_Count, Ack, X_Edge_OO_L, X_Edge_OO_R, Gap_Top, Gap_Bot, Bird_Y,
      output Stop, Hit_Pipe, Hit_Floor, Q_Idle, Q_Armed, Q_Eval, Q_Hit
   );
endinterface

// File: rtl/pipe_collision_check_box_overlap.sv
// flappy_box_overlap: combinational bird-box tests on one captured frame.
//   cap   in   captured pipe edges, gap and bird Y
//   x_ovl out  bird box and pipe overlap in X
//   pipe  out  X overlap and bird outside the gap
//   flr   out  bird below the floor or above the ceiling
module flappy_box_overlap
   import pipe_collision_check_pkg::*;
#(
   parameter int BIRD_X_L = BIRD_X_L_DEF,
   parameter int BIRD_X_R = BIRD_X_R_DEF,
   parameter int BIRD_H   = BIRD_H_DEF,
   parameter int FLOOR_Y  = FLOOR_Y_DEF,
   parameter int CEIL_Y   = CEIL_Y_DEF
) (
   input  coll_cap_t cap,
   output logic      x_ovl,
   output logic      pipe,
   output logic      flr
);

   logic [10:0] bird_bot;
   logic [10:0] ceil_diff;

   // 11 bits so a bird near the bottom cannot wrap back on-screen
   assign bird_bot = {1'b0, cap.bird_y} + 11'(BIRD_H);

   assign x_ovl = (cap.x_l <= 10'(BIRD_X_R)) && (cap.x_r >= 10'(BIRD_X_L));
   assign pipe  = x_ovl && ((cap.bird_y < cap.gap_top) || (bird_bot > {1'b0, cap.gap_bot}));

   // Bird_Y < CEIL_Y taken from the borrow of an 11-bit subtract; stays a
   // real comparison even when CEIL_Y is tuned to 0.
   assign ceil_diff = {1'b0, cap.bird_y} - 11'(CEIL_Y);
   assign flr       = (bird_bot > 11'(FLOOR_Y)) || ceil_diff[10];

endmodule

// File: rtl/pipe_collision_check.sv
// pipe_collision_check: once per frame, checks the bird box against the in-scope
// pipe, the floor and the ceiling. HIT_FRAMES consecutive colliding frames raise
// Stop, held until the game acknowledges with Ack.
//   clk, reset  system clock, synchronous active-high reset
//   bus         slave side of pipe_collision_check_if (controls, geometry, status)
// Pipeline: Frame_Tick in QArmed captures the geometry (stage 1), QEval judges it
// (stage 2), so Stop rises two cycles after the deciding tick.
module pipe_collision_check
   import pipe_collision_check_pkg::*;
#(
   parameter int BIRD_X_L   = BIRD_X_L_DEF,
   parameter int BIRD_X_R   = BIRD_X_R_DEF,
   parameter int BIRD_H     = BIRD_H_DEF,
   parameter int FLOOR_Y    = FLOOR_Y_DEF,
   parameter int CEIL_Y     = CEIL_Y_DEF,
   parameter int HIT_FRAMES = HIT_FRAMES_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   pipe_collision_check_if.slave bus
);

   localparam int CNT_W = $clog2(HIT_FRAMES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HIT_FRAMES);

   coll_state_e      state;
   coll_cap_t        cap;
   logic [CNT_W-1:0] hit_cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic             stop_q;
   logic             hit_pipe_q;
   logic             hit_floor_q;
   logic             x_ovl;
   logic             pipe_hit;
   logic             flr_hit;

   flappy_box_overlap #(
      .BIRD_X_L (BIRD_X_L),
      .BIRD_X_R (BIRD_X_R),
      .BIRD_H   (BIRD_H),
      .FLOOR_Y  (FLOOR_Y),
      .CEIL_Y   (CEIL_Y)
   ) u_overlap (
      .cap   (cap),
      .x_ovl (x_ovl),
      .pipe  (pipe_hit),
      .flr   (flr_hit)
   );

   // Saturating increment; a pipe-switch glitch can never overflow the counter
   assign cnt_inc = (hit_cnt == CNT_MAX) ? hit_cnt : hit_cnt + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         cap         <= '0;
         hit_cnt     <= '0;
         stop_q      <= 1'b0;
         hit_pipe_q  <= 1'b0;
         hit_floor_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               hit_cnt     <= '0;
               hit_pipe_q  <= 1'b0;
               hit_floor_q <= 1'b0;
               stop_q      <= 1'b0;
               if (bus.Q_Count) state <= S_ARMED;
            end
            S_ARMED: begin
               if (!bus.Q_Count) begin
                  state       <= S_IDLE;
                  hit_cnt     <= '0;
                  hit_pipe_q  <= 1'b0;
                  hit_floor_q <= 1'b0;
               end else if (bus.Frame_Tick) begin
                  cap.x_l     <= bus.X_Edge_OO_L;
                  cap.x_r     <= bus.X_Edge_OO_R;
                  cap.gap_top <= bus.Gap_Top;
                  cap.gap_bot <= bus.Gap_Bot;
                  cap.bird_y  <= bus.Bird_Y;
                  state       <= S_EVAL;
               end
            end
            S_EVAL: begin
               if (!bus.Q_Count) begin
                  state       <= S_IDLE;
                  hit_cnt     <= '0;
                  hit_pipe_q  <= 1'b0;
                  hit_floor_q <= 1'b0;
               end else if (pipe_hit || flr_hit) begin
                  hit_cnt     <= cnt_inc;
                  hit_pipe_q  <= hit_pipe_q | pipe_hit;
                  hit_floor_q <= hit_floor_q | flr_hit;
                  if (cnt_inc == CNT_MAX) begin
                     state  <= S_HIT;
                     stop_q <= 1'b1;
                  end else begin
                     state <= S_ARMED;
                  end
               end else begin
                  // A clean frame breaks the run
                  hit_cnt     <= '0;
                  hit_pipe_q  <= 1'b0;
                  hit_floor_q <= 1'b0;
                  state       <= S_ARMED;
               end
            end
            S_HIT: begin
               // Q_Count deliberately ignored: only the game's Ack releases Stop
               if (bus.Ack) begin
                  state  <= S_IDLE;
                  stop_q <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.Stop      = stop_q;
   assign bus.Hit_Pipe  = hit_pipe_q;
   assign bus.Hit_Floor = hit_floor_q;
   assign bus.Q_Idle    = (state == S_IDLE);
   assign bus.Q_Armed   = (state == S_ARMED);
   assign bus.Q_Eval    = (state == S_EVAL);
   assign bus.Q_Hit     = (state == S_HIT);

endmodule
